// File: rtl/data_mem_responder.sv
// Memory-side responder for the req/rdy/valid data-memory protocol.
// One outstanding load/store, parameterised ready delay and response latency.
module data_mem_responder #(
    parameter int addressSize = 32,
    parameter int dataSize    = 32,
    parameter int DEPTH       = 1024,
    parameter int RDY_DELAY   = 0,
    parameter int LATENCY     = 2
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   proc_req,
    input  logic                   we,
    input  logic [addressSize-1:0] addr,
    input  logic [dataSize-1:0]    wdata,
    output logic                   mem_rdy,
    output logic                   valid,
    output logic [dataSize-1:0]    rdata
);

    // state | meaning
    // IDLE  | no op; mem_rdy high only when RDY_DELAY==0
    // WAIT  | request seen, counting down RDY_DELAY before raising mem_rdy
    // READY | mem_rdy high, waiting for proc_req to complete the handshake
    // BUSY  | op latched, counting down LATENCY
    // RESP  | one-cycle valid pulse; store committed / load data on rdata

    localparam int         AW       = $clog2(DEPTH);
    localparam logic [3:0] RDY_LOAD = (RDY_DELAY > 0) ? 4'(RDY_DELAY - 1) : 4'd0;
    localparam logic [3:0] LAT_LOAD = 4'(LATENCY - 1);
    localparam logic       RDY_IDLE = (RDY_DELAY == 0) ? 1'b1 : 1'b0;

    typedef enum logic [2:0] {
        IDLE,
        WAIT,
        READY,
        BUSY,
        RESP
    } state_t;

    state_t                state;
    logic [3:0]            cnt;
    logic                  we_q;
    logic [AW-1:0]         idx_q;
    logic [dataSize-1:0]   wdata_q;
    logic [dataSize-1:0]   mem [DEPTH];
    logic                  handshake;
    logic                  finish_op;
    logic                  unused_addr;

    // mem_rdy is only ever high in IDLE (no delay) or READY, so this is the handshake.
    assign handshake   = proc_req & mem_rdy;
    assign finish_op   = (state == BUSY) && (cnt == 4'd0);
    assign unused_addr = ^{addr[addressSize-1:AW+2], addr[1:0]};

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            we_q    <= 1'b0;
            idx_q   <= '0;
            wdata_q <= '0;
        end else if (handshake) begin
            we_q    <= we;
            idx_q   <= addr[AW+1:2];
            wdata_q <= wdata;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state   <= IDLE;
            cnt     <= 4'd0;
            mem_rdy <= RDY_IDLE;
            valid   <= 1'b0;
            rdata   <= '0;
        end else begin
            valid <= 1'b0;
            case (state)
                IDLE: begin
                    if (handshake) begin
                        state   <= BUSY;
                        cnt     <= LAT_LOAD;
                        mem_rdy <= 1'b0;
                    end else if (proc_req && (RDY_DELAY > 0)) begin
                        state   <= WAIT;
                        cnt     <= RDY_LOAD;
                        mem_rdy <= 1'b0;
                    end
                end
                WAIT: begin
                    if (!proc_req) begin
                        state <= IDLE;
                    end else if (cnt == 4'd0) begin
                        state   <= READY;
                        mem_rdy <= 1'b1;
                    end else begin
                        cnt <= cnt - 4'd1;
                    end
                end
                READY: begin
                    if (handshake) begin
                        state   <= BUSY;
                        cnt     <= LAT_LOAD;
                        mem_rdy <= 1'b0;
                    end else begin
                        state   <= IDLE;
                        mem_rdy <= RDY_IDLE;
                    end
                end
                BUSY: begin
                    if (cnt == 4'd0) begin
                        state <= RESP;
                        valid <= 1'b1;
                        if (!we_q) begin
                            rdata <= mem[idx_q];
                        end
                    end else begin
                        cnt <= cnt - 4'd1;
                    end
                end
                RESP: begin
                    state   <= IDLE;
                    mem_rdy <= RDY_IDLE;
                end
                default: begin
                    state   <= IDLE;
                    mem_rdy <= RDY_IDLE;
                end
            endcase
        end
    end

    // Array is deliberately not reset; a store commits only on the edge entering RESP.
    always_ff @(posedge clk) begin
        if (finish_op && we_q) begin
            mem[idx_q] <= wdata_q;
        end
    end

endmodule
